// File: rtl/motoro3_pwm_gen.sv
// Complementary high/low PWM generator with dead time. Period and duty are
// latched into shadow registers at each period boundary.
module motoro3_pwm_gen #(
  parameter logic [15:0] MIN_PERIOD = 16'd64,
  parameter logic [15:0] DEAD       = 16'd4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic [15:0] plLen,
  input  logic [7:0]  pwmLenWant,
  input  logic [7:0]  pwmMinMask,
  output logic        pwmHi,
  output logic        pwmLo,
  output logic        periodStart,
  output logic        running,
  output logic [15:0] perCnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, n_state;
  logic [15:0] cnt, n_cnt;
  logic [15:0] per_s, n_per_s;
  logic [15:0] hi_s, n_hi_s;
  logic        sup, n_sup;
  logic        latch;

  logic [15:0] per_clamp;
  logic [23:0] duty_prod;
  logic        n_run;
  logic        n_pwm_hi, n_pwm_lo;

  assign per_clamp = (plLen < MIN_PERIOD) ? MIN_PERIOD : plLen;
  assign duty_prod = {8'd0, per_clamp} * {16'd0, pwmLenWant};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_per_s = per_s;
    n_hi_s  = hi_s;
    n_sup   = sup;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        n_cnt = 16'd0;
        if (enable) begin
          latch   = 1'b1;
          n_state = RUN;
        end
      end
      RUN: begin
        if (cnt == per_s - 16'd1) begin
          n_cnt = 16'd0;
          if (enable) latch = 1'b1;
          else        n_state = IDLE;
        end else begin
          n_cnt = cnt + 16'd1;
        end
      end
      default: n_state = IDLE;
    endcase
    if (latch) begin
      n_per_s = per_clamp;
      n_hi_s  = duty_prod[23:8];
      n_sup   = (pwmLenWant < pwmMinMask);
    end
  end

  // Outputs are decoded from next-state values so the flops line up with cnt.
  // The low-side threshold is 17 bits wide so hiS+DEAD cannot wrap.
  assign n_run    = (n_state == RUN);
  assign n_pwm_hi = n_run & ~n_sup & (n_cnt >= DEAD) & (n_cnt < n_hi_s);
  assign n_pwm_lo = n_run & ~n_sup &
                    ({1'b0, n_cnt} >= ({1'b0, n_hi_s} + {1'b0, DEAD}));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      per_s       <= 16'd0;
      hi_s        <= 16'd0;
      sup         <= 1'b0;
      pwmHi       <= 1'b0;
      pwmLo       <= 1'b0;
      periodStart <= 1'b0;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      per_s       <= n_per_s;
      hi_s        <= n_hi_s;
      sup         <= n_sup;
      pwmHi       <= n_pwm_hi;
      pwmLo       <= n_pwm_lo;
      periodStart <= latch;
    end
  end

  assign running = (state == RUN);
  assign perCnt  = cnt;

endmodule

// File: tb/tb_motoro3_pwm_gen.sv
// Self-checking bench for motoro3_pwm_gen: directed period scenarios plus
// random input traffic, compared cycle by cycle against a period-level model.
module tb_motoro3_pwm_gen;

  localparam int MIN_P = 64;
  localparam int DEAD  = 4;

  logic        clk = 1'b0;
  logic        nRst;
  logic        enable;
  logic [15:0] plLen;
  logic [7:0]  pwmLenWant;
  logic [7:0]  pwmMinMask;
  logic        pwmHi, pwmLo, periodStart, running;
  logic [15:0] perCnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, position in period, and latched period params.
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_per = 0;
  int m_hi  = 0;
  bit m_sup = 1'b0;

  motoro3_pwm_gen dut (
    .clk         (clk),
    .nRst        (nRst),
    .enable      (enable),
    .plLen       (plLen),
    .pwmLenWant  (pwmLenWant),
    .pwmMinMask  (pwmMinMask),
    .pwmHi       (pwmHi),
    .pwmLo       (pwmLo),
    .periodStart (periodStart),
    .running     (running),
    .perCnt      (perCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_latch(input int pl, input int want, input int mask);
    m_per = (pl < MIN_P) ? MIN_P : pl;
    m_hi  = (m_per * want) / 256;
    m_sup = (want < mask);
  endtask

  task automatic compare_all();
    bit e_hi, e_lo;
    e_hi = m_run && !m_sup && (m_pos >= DEAD) && (m_pos < m_hi);
    e_lo = m_run && !m_sup && (m_pos >= m_hi + DEAD);
    check("running",     int'(running),     int'(m_run));
    check("perCnt",      int'(perCnt),      m_pos);
    check("periodStart", int'(periodStart), int'(m_run && (m_pos == 0)));
    check("pwmHi",       int'(pwmHi),       int'(e_hi));
    check("pwmLo",       int'(pwmLo),       int'(e_lo));
  endtask

  // One clock: inputs seen at the edge drive the model, then all outputs are compared.
  task automatic step();
    bit en;
    int pl, w, mk;
    en = enable;
    pl = int'(plLen);
    w  = int'(pwmLenWant);
    mk = int'(pwmMinMask);
    @(posedge clk);
    #1;
    if (!m_run) begin
      m_pos = 0;
      if (en) begin
        model_latch(pl, w, mk);
        m_run = 1'b1;
      end
    end else if (m_pos == m_per - 1) begin
      m_pos = 0;
      if (en) model_latch(pl, w, mk);
      else    m_run = 1'b0;
    end else begin
      m_pos++;
    end
    compare_all();
  endtask

  // Runs from cnt 0 of a period to the next period start (or IDLE), counting
  // output cycles; at cycle change_at the inputs plLen/enable are rewritten.
  task automatic period_stats(input string tag, input int exp_len, input int exp_hi,
                              input int exp_lo, input int change_at, input int new_pl,
                              input bit new_en);
    int len, h, l;
    len = 0;
    h   = 0;
    l   = 0;
    do begin
      h += int'(pwmHi);
      l += int'(pwmLo);
      if (len == change_at) begin
        plLen  = 16'(new_pl);
        enable = new_en;
      end
      len++;
      step();
    end while (!periodStart && running && len < 1000);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_hi"},  h,   exp_hi);
    check({tag, "_lo"},  l,   exp_lo);
  endtask

  task automatic set_in(input int pl, input int want, input int mask);
    plLen      = 16'(pl);
    pwmLenWant = 8'(want);
    pwmMinMask = 8'(mask);
  endtask

  initial begin
    nRst   = 1'b0;
    enable = 1'b0;
    set_in(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    nRst = 1'b1;

    // Nominal 100-cycle period at 50 % duty.
    set_in(100, 128, 0);
    enable = 1'b1;
    step();
    check("first_start", int'(periodStart), 1);
    period_stats("p100", 100, 46, 46, 30, 200, 1'b1);

    // Period length change mid-period only takes effect at the next latch.
    set_in(100, 10, 20);
    period_stats("p200", 200, 96, 96, -1, 100, 1'b1);

    // Suppressed period, then clamped short period.
    set_in(10, 64, 0);
    period_stats("supp", 100, 0, 0, -1, 10, 1'b1);
    set_in(100, 128, 0);
    period_stats("clamp", 64, 12, 44, -1, 100, 1'b1);

    // Enable drop mid-period finishes the period, then idles.
    period_stats("drop", 100, 46, 46, 40, 100, 1'b0);
    check("drop_running", int'(running), 0);
    repeat (5) step();

    // Asynchronous reset while pwmHi is high.
    enable = 1'b1;
    step();
    repeat (20) step();
    check("rst_pre_hi", int'(pwmHi), 1);
    #2 nRst = 1'b0;
    #1;
    check("rst_hi",      int'(pwmHi),       0);
    check("rst_lo",      int'(pwmLo),       0);
    check("rst_running", int'(running),     0);
    check("rst_perCnt",  int'(perCnt),      0);
    check("rst_start",   int'(periodStart), 0);
    m_run = 1'b0;
    m_pos = 0;
    #3 nRst = 1'b1;
    step();
    check("rst_restart", int'(periodStart), 1);

    // Duty extremes and exact minimum period.
    set_in(100, 255, 0);
    period_stats("d128", 100, 46, 46, -1, 100, 1'b1);
    set_in(100, 0, 0);
    period_stats("d255", 100, 95, 0, -1, 100, 1'b1);
    set_in(64, 128, 0);
    period_stats("d0", 100, 0, 96, -1, 100, 1'b1);
    enable = 1'b0;
    period_stats("p64", 64, 28, 28, -1, 64, 1'b0);

    // Random traffic; inputs jitter at arbitrary points inside periods.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        set_in(int'($urandom_range(0, 300)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 40)));
        enable = ($urandom_range(0, 7) != 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
